receiver: RTL and testbench
===========================

Name: receiver

Overview:
- UART receive stage: consumes the serial line driven by the team's transmitter (8N1, LSB first, idle high). Produces bytes into an 8-deep receive FIFO.
- Oversamples the line with a baud tick, finds start bits, samples each bit at mid-cell and checks the stop bit.
- Buffers good bytes for the host side, using a show-ahead read interface.

Parameters:
- OVERSAMPLE, 16, number of i_baud ticks per bit cell; even, >= 4.
- DEPTH, 8, receive FIFO entries; power of 2.

Ports:
- i_clk  input  1  system clock; single clock domain.
- i_rst  input  1  synchronous, active-high reset.
- i_baud  input  1  one-cycle tick at OVERSAMPLE x bit rate.
- i_rx  input  1  asynchronous serial line, idle high.
- i_read  input  1  pop the head byte; ignored when o_empty=1.
- o_D  output  8  head byte of FIFO; valid when o_empty=0.
- o_empty  output  1  FIFO holds no bytes.
- o_full  output  1  FIFO holds DEPTH bytes.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: good byte dropped because FIFO full.

Behaviour:
- Reset (i_rst=1 at posedge i_clk):
  - FSM goes to IDLE; synchronizer flops are set to 1.
  - FIFO pointers and count are cleared; o_empty=1, o_full=0, o_D=0.
  - o_frame_err=0, o_overrun=0.
  - A frame in progress is abandoned. No partial byte is ever pushed.
- Input: i_rx passes through a 2-flop synchronizer before any use; the output is rx_s.
- Tick counter and bit index: all FSM timing advances only on cycles with i_baud=1. tick_cnt is log2(OVERSAMPLE) bits wide; bit_idx is 3 bits.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START: count ticks. At tick_cnt=OVERSAMPLE/2-1, sample rx_s.
  - rx_s=1: false start; return to IDLE with no output.
  - rx_s=0: go to DATA with tick_cnt=0 and bit_idx=0.
- DATA: when tick_cnt reaches OVERSAMPLE-1, sample rx_s into shift[bit_idx] (LSB first) and clear tick_cnt.
  - After bit_idx=7 is sampled, go to STOP.
- STOP: when tick_cnt reaches OVERSAMPLE-1, sample rx_s.
  - rx_s=1: push shift into the FIFO (see FIFO rules) and go to IDLE.
  - rx_s=0: pulse o_frame_err, discard the byte, go to BREAK.
- BREAK: stay until a tick with rx_s=1, then go to IDLE. A held-low line therefore yields exactly one o_frame_err.
- Latency: a pushed byte appears on o_D, with o_empty=0, on the cycle after the stop-bit sample.
- FIFO rules:
  - Circular buffer with r_ptr and w_ptr of log2(DEPTH) bits; both wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits. o_full = (count==DEPTH); o_empty = (count==0).
  - o_D = mem[r_ptr], combinational from registered state.
  - Pop when i_read=1 and o_empty=0. A read while empty has no effect.
  - Push while full and no pop in the same cycle: byte dropped, o_overrun pulses 1 cycle, existing contents unchanged.
  - Push and pop in the same cycle: both take effect and count is unchanged, including when full. No overrun in that case.
  - A push into an empty FIFO with a simultaneous i_read: the read is ignored (o_empty was 1); the byte is stored.
- Outputs o_frame_err and o_overrun are registered.

Decomposition:
- uart_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, STOP, BREAK.
  - Frame constants: DATA_BITS=8, IDLE_LEVEL=1'b1.
- One sub-module, char_r: synchronizer, FSM and shift register. It outputs o_char[7:0] and a one-cycle o_done (good stop bit) and o_ferr.
- receiver instantiates char_r and implements the FIFO inline.

Test Plan:
- Send 0xA5 (OVERSAMPLE=16, tick every 4 clocks): o_D=8'hA5 and o_empty falls 1 cycle after the stop sample; i_read pulse then gives o_empty=1.
- Low glitch of 4 ticks on idle line: FSM returns to IDLE at the mid-start sample; o_empty stays 1 and o_frame_err stays 0.
- Send 0x3C with stop bit forced 0, then hold the line low for 40 bit times: exactly one o_frame_err pulse and FIFO empty. A following 0x81 is received correctly.
- Send 0x00..0x08 with no reads: o_full=1 after 0x07 and o_overrun pulses once on 0x08. Eight reads return 0x00..0x07 in order, then o_empty=1.
- FIFO full, with i_read asserted on the push cycle of 0x55: no overrun, o_full stays 1, and the tail entry is 0x55.
- Assert i_rst mid-DATA of 0x5A, release, send 0xC3: only 0xC3 is received, with no spurious error pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents: receiver FSM state encoding and 8N1 frame constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/receiver_char_r.sv
// char_r: character receiver for 8N1 serial frames, LSB first, idle high.
// Synchronizes the line, finds start bits, samples each bit mid-cell and
// checks the stop bit.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_baud       : one-cycle tick at OVERSAMPLE x bit rate
//   i_rx         : asynchronous serial line
//   o_char       : assembled byte, valid while o_done is high
//   o_done       : one-cycle pulse, good stop bit sampled
//   o_ferr       : one-cycle pulse, stop bit sampled low
module char_r
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_baud,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_char,
   output logic                 o_done,
   output logic                 o_ferr
);

   localparam int             TW       = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0]  MID      = TW'(OVERSAMPLE/2 - 1);
   localparam logic [TW-1:0]  LAST     = TW'(OVERSAMPLE - 1);
   localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

   logic                 rx_m;
   logic                 rx_s;
   rx_state_t            state;
   rx_state_t            state_n;
   logic [TW-1:0]        tick_cnt;
   logic [TW-1:0]        tick_n;
   logic [2:0]           bit_idx;
   logic [2:0]           bit_n;
   logic                 sample_bit;
   logic                 stop_sample;
   logic [DATA_BITS-1:0] shift;

   // Two-flop synchronizer; preset to the idle level so reset never looks
   // like a start bit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_m <= IDLE_LEVEL;
         rx_s <= IDLE_LEVEL;
      end else begin
         rx_m <= i_rx;
         rx_s <= rx_m;
      end
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_n;
         bit_idx  <= bit_n;
      end
   end

   // Data shift register carries no reset; a frame is only accepted after
   // all eight bits have been written.
   always_ff @(posedge i_clk) begin
      if (sample_bit) shift[bit_idx] <= rx_s;
   end

   // Next-state logic; all timing advances on baud ticks only.
   always_comb begin
      state_n    = state;
      tick_n     = tick_cnt;
      bit_n      = bit_idx;
      sample_bit = 1'b0;
      if (i_baud) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_n = START;
                  tick_n  = '0;
               end
            end
            START: begin
               if (tick_cnt == MID) begin
                  tick_n = '0;
                  if (rx_s) begin
                     state_n = IDLE;
                  end else begin
                     state_n = DATA;
                     bit_n   = '0;
                  end
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tick_cnt == LAST) begin
                  sample_bit = 1'b1;
                  tick_n     = '0;
                  bit_n      = bit_idx + 3'd1;
                  if (bit_idx == LAST_BIT) state_n = STOP;
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
            STOP: begin
               if (tick_cnt == LAST) begin
                  tick_n  = '0;
                  state_n = rx_s ? IDLE : BREAK;
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
            BREAK: begin
               // Held-low line: wait for the line to return high so a
               // long break reports a single framing error.
               if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Outputs
   always_comb begin
      stop_sample = (state == STOP) && i_baud && (tick_cnt == LAST);
      o_done      = stop_sample && rx_s;
      o_ferr      = stop_sample && !rx_s;
      o_char      = shift;
   end

endmodule

// File: rtl/receiver.sv
// receiver: UART receive stage with an 8N1 character receiver feeding a
// show-ahead receive FIFO.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_baud       : one-cycle tick at OVERSAMPLE x bit rate
//   i_rx         : asynchronous serial line, idle high
//   i_read       : pop the head byte; ignored when empty
//   o_D          : head byte of the FIFO, valid when o_empty=0
//   o_empty      : FIFO holds no bytes
//   o_full       : FIFO holds DEPTH bytes
//   o_frame_err  : one-cycle pulse, stop bit sampled low
//   o_overrun    : one-cycle pulse, good byte dropped because FIFO full
module receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int DEPTH      = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_baud,
   input  logic                 i_rx,
   input  logic                 i_read,
   output logic [DATA_BITS-1:0] o_D,
   output logic                 o_empty,
   output logic                 o_full,
   output logic                 o_frame_err,
   output logic                 o_overrun
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_BITS-1:0] char_val;
   logic                 done;
   logic                 ferr;
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]        r_ptr;
   logic [AW-1:0]        w_ptr;
   logic [AW:0]          count;
   logic                 pop;
   logic                 push_ok;

   char_r #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_char (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_baud (i_baud),
      .i_rx   (i_rx),
      .o_char (char_val),
      .o_done (done),
      .o_ferr (ferr)
   );

   // A push is accepted when there is room, or when a pop frees the head
   // slot in the same cycle (count then stays put, even when full).
   always_comb begin
      pop     = i_read && !o_empty;
      push_ok = done && (!o_full || pop);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr       <= '0;
         w_ptr       <= '0;
         count       <= '0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         o_frame_err <= ferr;
         o_overrun   <= done && !push_ok;
         if (push_ok) begin
            mem[w_ptr] <= char_val;
            w_ptr      <= w_ptr + 1'b1;
         end
         if (pop) r_ptr <= r_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      o_D     = mem[r_ptr];
      o_empty = (count == '0);
      o_full  = (count == FULL_CNT);
   end

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: a table of single frames plus hand-written
// sequences for latency, glitch, break, overrun, full-with-read and reset.
module tb_receiver;

   localparam int OS    = 16;
   localparam int DEPTH = 8;
   localparam int CPB   = OS * 4;   // clocks per bit, baud tick every 4 clocks

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_empty;
      int         exp_ferr;
   } vec_t;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       baud     = 1'b0;
   logic       rx       = 1'b1;
   logic       read_drv = 1'b0;
   logic       auto_rd  = 1'b0;
   logic       read;
   logic [7:0] d;
   logic       empty;
   logic       full;
   logic       ferr;
   logic       ovr;
   logic [1:0] div      = 2'd0;

   int n_cmp    = 0;
   int n_bad    = 0;
   int ferr_cnt = 0;
   int ovr_cnt  = 0;

   vec_t tbl [5];

   receiver #(
      .OVERSAMPLE (OS),
      .DEPTH      (DEPTH)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_baud      (baud),
      .i_rx        (rx),
      .i_read      (read),
      .o_D         (d),
      .o_empty     (empty),
      .o_full      (full),
      .o_frame_err (ferr),
      .o_overrun   (ovr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      div  <= div + 2'd1;
      baud <= (div == 2'd3);
   end

   always @(posedge clk) begin
      if (ferr) ferr_cnt <= ferr_cnt + 1;
      if (ovr)  ovr_cnt  <= ovr_cnt + 1;
   end

   // auto_rd raises i_read exactly on the receiver's push cycle.
   assign read = read_drv | (auto_rd & dut.u_char.o_done);

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      rx = stop;
      repeat (CPB) @(posedge clk);
      rx = 1'b1;
   endtask

   task automatic idle(input int nbits);
      rx = 1'b1;
      repeat (nbits * CPB) @(posedge clk);
   endtask

   task automatic pop_chk(input string nm, input logic [7:0] exp);
      @(negedge clk);
      chk({nm, " empty"}, int'(empty), 0);
      chk(nm, int'(d), int'(exp));
      read_drv = 1'b1;
      @(posedge clk);
      #1 read_drv = 1'b0;
   endtask

   initial begin
      int f0;
      int o0;
      int lat;

      tbl[0] = '{data: 8'h00, stop: 1'b1, exp_empty: 1'b0, exp_ferr: 0};
      tbl[1] = '{data: 8'hFF, stop: 1'b1, exp_empty: 1'b0, exp_ferr: 0};
      tbl[2] = '{data: 8'h6E, stop: 1'b1, exp_empty: 1'b0, exp_ferr: 0};
      tbl[3] = '{data: 8'h92, stop: 1'b0, exp_empty: 1'b1, exp_ferr: 1};
      tbl[4] = '{data: 8'h01, stop: 1'b1, exp_empty: 1'b0, exp_ferr: 0};

      // reset state
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("reset empty", int'(empty), 1);
      chk("reset full", int'(full), 0);
      chk("reset D", int'(d), 0);
      chk("reset frame_err", int'(ferr), 0);
      chk("reset overrun", int'(ovr), 0);
      rst = 1'b0;
      idle(2);

      // 0xA5: byte appears shortly after mid-stop-bit, then read empties
      begin
         logic [7:0] b;
         b   = 8'hA5;
         lat = -1;
         rx  = 1'b0;
         repeat (CPB) @(posedge clk);
         for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
         end
         rx = 1'b1;
         for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (!empty) begin
               lat = k;
               break;
            end
         end
         chk("a5 latency window", int'(lat >= 30 && lat <= 40), 1);
         idle(1);
         chk("a5 full", int'(full), 0);
         pop_chk("a5 data", 8'hA5);
         @(negedge clk);
         chk("a5 empty after read", int'(empty), 1);
      end

      // table of single frames
      for (int i = 0; i < 5; i++) begin
         f0 = ferr_cnt;
         send_bits(tbl[i].data, tbl[i].stop);
         idle(1);
         @(negedge clk);
         chk($sformatf("vec%0d frame_err count", i), ferr_cnt - f0, tbl[i].exp_ferr);
         chk($sformatf("vec%0d empty", i), int'(empty), int'(tbl[i].exp_empty));
         if (!tbl[i].exp_empty) pop_chk($sformatf("vec%0d data", i), tbl[i].data);
         @(negedge clk);
         chk($sformatf("vec%0d empty after", i), int'(empty), 1);
      end

      // short low glitch: false start
      f0 = ferr_cnt;
      rx = 1'b0;
      repeat (16) @(posedge clk);
      idle(2);
      @(negedge clk);
      chk("glitch empty", int'(empty), 1);
      chk("glitch frame_err count", ferr_cnt - f0, 0);

      // bad stop bit followed by a 40-bit break: one error, then recovery
      f0 = ferr_cnt;
      send_bits(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (40 * CPB) @(posedge clk);
      idle(2);
      @(negedge clk);
      chk("break frame_err count", ferr_cnt - f0, 1);
      chk("break empty", int'(empty), 1);
      send_bits(8'h81, 1'b1);
      idle(1);
      pop_chk("after break data", 8'h81);
      chk("after break frame_err count", ferr_cnt - f0, 1);

      // fill, overrun on the ninth byte, drain in order
      o0 = ovr_cnt;
      for (int i = 0; i < 8; i++) begin
         send_bits(8'(i), 1'b1);
         idle(1);
         @(negedge clk);
         if (i == 6) chk("fill full after 0x06", int'(full), 0);
         if (i == 7) chk("fill full after 0x07", int'(full), 1);
      end
      send_bits(8'h08, 1'b1);
      idle(1);
      @(negedge clk);
      chk("overrun count", ovr_cnt - o0, 1);
      chk("overrun full", int'(full), 1);
      for (int i = 0; i < 8; i++) pop_chk($sformatf("drain %0d", i), 8'(i));
      @(negedge clk);
      chk("drain empty", int'(empty), 1);

      // full FIFO with read on the push cycle of 0x55
      for (int i = 0; i < 8; i++) begin
         send_bits(8'h10 + 8'(i), 1'b1);
         idle(1);
      end
      o0 = ovr_cnt;
      auto_rd = 1'b1;
      send_bits(8'h55, 1'b1);
      idle(1);
      auto_rd = 1'b0;
      @(negedge clk);
      chk("push+pop overrun count", ovr_cnt - o0, 0);
      chk("push+pop full", int'(full), 1);
      for (int i = 1; i < 8; i++) pop_chk($sformatf("push+pop drain %0d", i), 8'h10 + 8'(i));
      pop_chk("push+pop tail", 8'h55);
      @(negedge clk);
      chk("push+pop empty", int'(empty), 1);

      // reset in the middle of 0x5A, then 0xC3
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      rx = 1'b1;
      repeat (CPB) @(posedge clk);
      rx = 1'b0;
      repeat (CPB / 2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      idle(3);
      @(negedge clk);
      chk("mid reset empty", int'(empty), 1);
      send_bits(8'hC3, 1'b1);
      idle(1);
      @(negedge clk);
      chk("mid reset frame_err count", ferr_cnt - f0, 0);
      chk("mid reset overrun count", ovr_cnt - o0, 0);
      pop_chk("mid reset data", 8'hC3);
      @(negedge clk);
      chk("mid reset empty after", int'(empty), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
